mem_arbiter: RTL

Memory responder on the far side of the CPU's inst_mem_* and data_mem_* request interfaces. It accepts instruction-fetch and data read/write requests and serialises them onto one shared lower-level memory port (pmem_*). It returns a one-cycle resp pulse to the requesting client. It sits between the pipeline control/datapath and the L2/physical memory.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_grant_select.sv | 32 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-client memory arbiter: FSM states and grant encoding.
package mem_arbiter_types;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      INST_BUSY = 2'd1,
      DATA_BUSY = 2'd2,
      RESP      = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_INST = 1'b0,
      GRANT_DATA = 1'b1
   } arb_grant_t;

   function automatic logic is_busy(input arb_state_t s);
      return (s == INST_BUSY) || (s == DATA_BUSY);
   endfunction

endpackage

// File: rtl/mem_arbiter_grant_select.sv
// Combinational grant decision between the instruction and data clients.
// With ARB_FAIRNESS_EN defined, a starved instruction client overrides data priority once.
module arb_grant_select
   import mem_arbiter_types::*;
(
   input  logic       inst_req,
   input  logic       data_req,
   input  logic       inst_starved,
   output arb_grant_t grant,
   output logic       req_valid
);

   always_comb begin
      req_valid = inst_req | data_req;
      grant     = GRANT_INST;
`ifdef ARB_FAIRNESS_EN
      if (data_req && !(inst_req && inst_starved)) begin
         grant = GRANT_DATA;
      end
`else
      if (data_req) begin
         grant = GRANT_DATA;
      end
`endif
   end

`ifndef ARB_FAIRNESS_EN
   logic unused_starved;
   assign unused_starved = inst_starved;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction and data cache-line requests onto one physical memory port.
// Optional macro ARB_FAIRNESS_EN lets a waiting fetch win after one data transaction.
module mem_arbiter
   import mem_arbiter_types::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  inst_mem_read,
   input  logic [ADDR_WIDTH-1:0] inst_mem_address,
   output logic [DATA_WIDTH-1:0] inst_mem_rdata,
   output logic                  inst_mem_resp,

   input  logic                  data_mem_read,
   input  logic                  data_mem_write,
   input  logic [ADDR_WIDTH-1:0] data_mem_address,
   input  logic [DATA_WIDTH-1:0] data_mem_wdata,
   output logic [DATA_WIDTH-1:0] data_mem_rdata,
   output logic                  data_mem_resp,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [DATA_WIDTH-1:0] pmem_wdata,
   input  logic [DATA_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   arb_state_t state, next_state;
   arb_grant_t grant_q;
   arb_grant_t sel_grant;
   logic       sel_valid;
   logic       is_write_q;
   logic       data_req;
   logic       inst_starved;
   logic       take_req;

   assign data_req = data_mem_read | data_mem_write;
   assign take_req = (state == IDLE) && sel_valid;

   arb_grant_select u_grant_select (
      .inst_req     (inst_mem_read),
      .data_req     (data_req),
      .inst_starved (inst_starved),
      .grant        (sel_grant),
      .req_valid    (sel_valid)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               next_state = (sel_grant == GRANT_DATA) ? DATA_BUSY : INST_BUSY;
            end
         end
         INST_BUSY, DATA_BUSY: begin
            if (pmem_resp) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Strobes and responses decode straight from registered state, so they are glitch-free.
   always_comb begin
      pmem_read     = (state == INST_BUSY) || ((state == DATA_BUSY) && !is_write_q);
      pmem_write    = (state == DATA_BUSY) && is_write_q;
      inst_mem_resp = (state == RESP) && (grant_q == GRANT_INST);
      data_mem_resp = (state == RESP) && (grant_q == GRANT_DATA);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         grant_q        <= GRANT_INST;
         is_write_q     <= 1'b0;
         pmem_address   <= '0;
         pmem_wdata     <= '0;
         inst_mem_rdata <= '0;
         data_mem_rdata <= '0;
      end else begin
         state <= next_state;

         if (take_req) begin
            grant_q <= sel_grant;
            if (sel_grant == GRANT_DATA) begin
               pmem_address <= data_mem_address;
               pmem_wdata   <= data_mem_wdata;
               is_write_q   <= data_mem_write;
            end else begin
               pmem_address <= inst_mem_address;
               is_write_q   <= 1'b0;
            end
         end

         // Write completions leave the data read register untouched.
         if (is_busy(state) && pmem_resp) begin
            if (grant_q == GRANT_INST) begin
               inst_mem_rdata <= pmem_rdata;
            end else if (!is_write_q) begin
               data_mem_rdata <= pmem_rdata;
            end
         end
      end
   end

`ifdef ARB_FAIRNESS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         inst_starved <= 1'b0;
      end else if (take_req) begin
         if (sel_grant == GRANT_INST) begin
            inst_starved <= 1'b0;
         end else if (inst_mem_read) begin
            inst_starved <= 1'b1;
         end
      end
   end
`else
   assign inst_starved = 1'b0;
`endif

endmodule
